// File: rtl/strobe_capture_arb_pkg.sv
// Shared defaults, the clog2 helper and the output-stage state encoding
// for the strobe capture arbiter and its per-channel buffers.
package strobe_capture_arb_pkg;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_NUM_BITS     = 16;
    localparam int DEF_DEPTH        = 4;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } out_state_t;

endpackage

// File: rtl/strobe_capture_arb_sync_fifo_small.sv
// Small per-channel FIFO: a write is taken when not full, or when full and
// popped on the same edge; otherwise the word is dropped and flagged.
module sync_fifo_small
    import strobe_capture_arb_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [NUM_BITS-1:0] wr_data,
    input  logic                rd_en,
    output logic [NUM_BITS-1:0] rd_data,
    output logic                empty,
    output logic                drop
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH) + 1;

    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic                full;
    logic                wr_accept;
    logic                rd_accept;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign wr_accept = wr_en && (!full || rd_en);
    assign rd_accept = rd_en && !empty;
    assign drop      = wr_en && full && !rd_en;

    // Head word is read asynchronously so a freshly written word can reach
    // the output register on the very next edge.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/strobe_capture_arb.sv
// Captures per-channel strobed words into small FIFOs and serialises them
// through a round-robin arbiter into a one-word valid/ready output register.
module strobe_capture_arb
    import strobe_capture_arb_pkg::*;
#(
    parameter int  NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int  NUM_BITS     = DEF_NUM_BITS,
    parameter int  DEPTH        = DEF_DEPTH,
    localparam int CHAN_W       = (clog2(NUM_CHANNELS) > 1) ? clog2(NUM_CHANNELS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CHANNELS-1:0]          enable,
    input  logic [NUM_CHANNELS*NUM_BITS-1:0] bits_in,
    output logic                             valid,
    input  logic                             ready,
    output logic [NUM_BITS-1:0]              bits_out,
    output logic [CHAN_W-1:0]                chan_out,
    output logic [NUM_CHANNELS-1:0]          overflow,
    input  logic                             overflow_clr
);

    logic [NUM_BITS-1:0]     fifo_data [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [NUM_CHANNELS-1:0] fifo_drop;
    logic [NUM_CHANNELS-1:0] fifo_pop;

    out_state_t              state_reg;
    logic [NUM_BITS-1:0]     bits_out_reg;
    logic [CHAN_W-1:0]       chan_out_reg;
    logic [CHAN_W-1:0]       rr_ptr_reg;
    logic [NUM_CHANNELS-1:0] overflow_reg;

    logic                    grant_found;
    logic [CHAN_W-1:0]       grant_idx;
    logic                    load;
    logic [CHAN_W-1:0]       rr_next;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            sync_fifo_small #(
                .NUM_BITS (NUM_BITS),
                .DEPTH    (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (enable[gi]),
                .wr_data (bits_in[gi*NUM_BITS +: NUM_BITS]),
                .rd_en   (fifo_pop[gi]),
                .rd_data (fifo_data[gi]),
                .empty   (fifo_empty[gi]),
                .drop    (fifo_drop[gi])
            );
        end
    endgenerate

    // Round-robin search starting at rr_ptr_reg, wrapping modulo NUM_CHANNELS.
    always_comb begin
        logic [CHAN_W:0] idx_wide;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_wide    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx_wide = {1'b0, rr_ptr_reg} + (CHAN_W+1)'(i);
            if (idx_wide >= (CHAN_W+1)'(NUM_CHANNELS)) begin
                idx_wide = idx_wide - (CHAN_W+1)'(NUM_CHANNELS);
            end
            if (!grant_found && !fifo_empty[idx_wide[CHAN_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_wide[CHAN_W-1:0];
            end
        end
    end

    assign load    = grant_found && ((state_reg == EMPTY) || ready);
    assign rr_next = (grant_idx == CHAN_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        fifo_pop = '0;
        if (load) begin
            fifo_pop[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            bits_out_reg <= '0;
            chan_out_reg <= '0;
            rr_ptr_reg   <= '0;
            overflow_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (grant_found) begin
                        state_reg <= LOADED;
                    end
                end
                LOADED: begin
                    if (ready && !grant_found) begin
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
            if (load) begin
                bits_out_reg <= fifo_data[grant_idx];
                chan_out_reg <= grant_idx;
                rr_ptr_reg   <= rr_next;
            end
            // A drop on the same edge as a clear leaves the flag set.
            overflow_reg <= overflow_clr ? fifo_drop : (overflow_reg | fifo_drop);
        end
    end

    assign valid    = (state_reg == LOADED);
    assign bits_out = bits_out_reg;
    assign chan_out = chan_out_reg;
    assign overflow = overflow_reg;

endmodule
